crc_stream_engine: RTL and testbench

- Parametrised, streaming CRC engine: polynomial, CRC width, data-path width, init value, reflection and final XOR are all parameters.
- Consumes framed data words with a valid/ready handshake and byte-lane keep on the last beat.
- Presents one CRC result per frame, plus a residue-match flag, through a valid/ready output.
- Successor to the fixed 16-bit, 16-bit-input CRC register; used by link-layer framers and checkers.

---
 rtl/crc_stream_engine.sv | 143 ++++++++++++++
 tb/tb_crc_stream_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: parametrised polynomial, width, init, reflection and
// final XOR. Accepts framed words over valid/ready with a byte-lane keep on the
// last beat, and presents one registered CRC result per frame over valid/ready.
module crc_stream_engine #(
  parameter int               CRC_W       = 16,
  parameter int               DATA_W      = 16,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(16'h8005),
  parameter logic [CRC_W-1:0] INIT        = '1,
  parameter bit               REFLECT_IN  = 1'b1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter logic [CRC_W-1:0] XOR_OUT     = '0,
  parameter logic [CRC_W-1:0] RESIDUE     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CRC_W-1:0]    crc_out,
  output logic                crc_ok,
  output logic                crc_valid,
  input  logic                crc_ready,
  output logic                busy
);

  localparam int LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CRC_W-1:0] lfsr_reg;
  logic [CRC_W-1:0] crc_out_reg;
  logic             crc_ok_reg;

  logic             accept;
  logic [LANES-1:0] lane_en;
  logic [CRC_W-1:0] lane_crc [LANES+1];
  logic [CRC_W-1:0] result_next;

  // One serial LFSR step for a single input bit.
  function automatic logic [CRC_W-1:0] crc_bit(input logic [CRC_W-1:0] lfsr,
                                               input logic b);
    logic fb;
    fb = lfsr[CRC_W-1] ^ b;
    return {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // Eight bit steps for one byte; bit order selected by REFLECT_IN.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] lfsr,
                                                input logic [7:0] data);
    logic [CRC_W-1:0] acc;
    acc = lfsr;
    for (int i = 0; i < 8; i++) begin
      acc = crc_bit(acc, REFLECT_IN ? data[i] : data[7-i]);
    end
    return acc;
  endfunction

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

  assign accept = in_valid && in_ready;

  // Lane chain: lane 0 is first in time; keep only gates lanes on the last beat.
  assign lane_crc[0] = lfsr_reg;
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_en[gi]      = !in_last || in_keep[gi];
    assign lane_crc[gi + 1] = lane_en[gi] ? crc_byte(lane_crc[gi], in_data[8*gi +: 8])
                                          : lane_crc[gi];
  end

  assign result_next = (REFLECT_OUT ? bitrev(lane_crc[LANES]) : lane_crc[LANES]) ^ XOR_OUT;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and handshake outputs from registered state only.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    crc_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = in_last ? RESULT : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && in_last) state_next = RESULT;
      end
      RESULT: begin
        crc_valid = 1'b1;
        if (crc_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  // CRC register and result capture; clr overrides any beat in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg    <= INIT;
      crc_out_reg <= '0;
      crc_ok_reg  <= 1'b0;
    end else if (clr) begin
      lfsr_reg <= INIT;
    end else if (accept) begin
      lfsr_reg <= lane_crc[LANES];
      if (in_last) begin
        crc_out_reg <= result_next;
        crc_ok_reg  <= (result_next == RESIDUE);
      end
    end else if (state_reg == RESULT && crc_ready) begin
      lfsr_reg <= INIT;
    end
  end

  assign crc_out = crc_out_reg;
  assign crc_ok  = crc_ok_reg;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: three configurations (CRC-16/MODBUS on
// 16-bit data, CRC-16/CCITT-FALSE on 8-bit data, CRC-32 on 32-bit data).
module tb_crc_stream_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: CRC-16/MODBUS, DATA_W=16
  logic [15:0] d0_data = '0;
  logic [1:0]  d0_keep = '0;
  logic        d0_last = 1'b0, d0_valid = 1'b0, d0_ready, d0_ok, d0_cv, d0_crdy = 1'b1, d0_busy;
  logic [15:0] d0_crc;

  // Instance 1: CRC-16/CCITT-FALSE, DATA_W=8
  logic [7:0]  d1_data = '0;
  logic [0:0]  d1_keep = '0;
  logic        d1_last = 1'b0, d1_valid = 1'b0, d1_ready, d1_ok, d1_cv, d1_crdy = 1'b1, d1_busy;
  logic [15:0] d1_crc;

  // Instance 2: CRC-32, DATA_W=32
  logic [31:0] d2_data = '0;
  logic [3:0]  d2_keep = '0;
  logic        d2_last = 1'b0, d2_valid = 1'b0, d2_ready, d2_ok, d2_cv, d2_crdy = 1'b1, d2_busy;
  logic [31:0] d2_crc;

  crc_stream_engine u_dut0 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(d0_data), .in_keep(d0_keep), .in_last(d0_last), .in_valid(d0_valid),
    .in_ready(d0_ready), .crc_out(d0_crc), .crc_ok(d0_ok), .crc_valid(d0_cv),
    .crc_ready(d0_crdy), .busy(d0_busy)
  );

  crc_stream_engine #(
    .CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF),
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .XOR_OUT(16'h0000), .RESIDUE(16'h0000)
  ) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(d1_data), .in_keep(d1_keep), .in_last(d1_last), .in_valid(d1_valid),
    .in_ready(d1_ready), .crc_out(d1_crc), .crc_ok(d1_ok), .crc_valid(d1_cv),
    .crc_ready(d1_crdy), .busy(d1_busy)
  );

  crc_stream_engine #(
    .CRC_W(32), .DATA_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF), .RESIDUE(32'h0)
  ) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(d2_data), .in_keep(d2_keep), .in_last(d2_last), .in_valid(d2_valid),
    .in_ready(d2_ready), .crc_out(d2_crc), .crc_ok(d2_ok), .crc_valid(d2_cv),
    .crc_ready(d2_crdy), .busy(d2_busy)
  );

  typedef struct packed {
    logic [1:0]   sel;   // which instance
    logic [4:0]   len;   // number of data bytes
    logic [127:0] data;  // byte k at data[8k+:8]
    logic         tail;  // close with an extra keep=0 last beat
    logic [31:0]  crc;   // expected crc_out
    logic         ok;    // expected crc_ok
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [10];

  function automatic vec_t mk(input int sel, input string s, input bit tail,
                              input logic [31:0] crc, input bit ok);
    vec_t v;
    v      = '0;
    v.sel  = 2'(sel);
    v.len  = 5'(s.len());
    for (int i = 0; i < s.len(); i++) v.data[8*i +: 8] = s[i];
    v.tail = tail;
    v.crc  = crc;
    v.ok   = ok;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_crc(input int sel);
    case (sel)
      0:       return {16'h0, d0_crc};
      1:       return {16'h0, d1_crc};
      default: return d2_crc;
    endcase
  endfunction

  function automatic logic [2:0] get_flags(input int sel);  // {crc_valid, crc_ok, in_ready}
    case (sel)
      0:       return {d0_cv, d0_ok, d0_ready};
      1:       return {d1_cv, d1_ok, d1_ready};
      default: return {d2_cv, d2_ok, d2_ready};
    endcase
  endfunction

  task automatic drive_beat(input int sel, input logic [31:0] data,
                            input logic [3:0] keep, input logic last);
    @(negedge clk);
    case (sel)
      0: begin d0_data = data[15:0]; d0_keep = keep[1:0]; d0_last = last; d0_valid = 1'b1; end
      1: begin d1_data = data[7:0];  d1_keep = keep[0:0]; d1_last = last; d1_valid = 1'b1; end
      default: begin d2_data = data; d2_keep = keep; d2_last = last; d2_valid = 1'b1; end
    endcase
  endtask

  task automatic release_inputs();
    d0_valid = 1'b0; d0_last = 1'b0;
    d1_valid = 1'b0; d1_last = 1'b0;
    d2_valid = 1'b0; d2_last = 1'b0;
  endtask

  // Sends a frame; ends on the negedge after the accepting edge of the last beat.
  task automatic drive_frame(input vec_t v);
    int w, nb, idx;
    logic [31:0] word;
    logic [3:0]  mask;
    logic        last;
    w  = (v.sel == 0) ? 2 : (v.sel == 1) ? 1 : 4;
    nb = (int'(v.len) + w - 1) / w;
    for (int b = 0; b < nb; b++) begin
      word = $urandom;
      mask = '0;
      for (int k = 0; k < w; k++) begin
        idx = b * w + k;
        if (idx < int'(v.len)) begin
          word[8*k +: 8] = v.data[8*idx +: 8];
          mask[k]        = 1'b1;
        end
      end
      last = (b == nb - 1) && !v.tail;
      // keep on non-last beats is garbage and must be ignored
      drive_beat(int'(v.sel), word, last ? mask : 4'($urandom), last);
    end
    if (v.tail || nb == 0) drive_beat(int'(v.sel), $urandom, 4'h0, 1'b1);
    @(negedge clk);
    release_inputs();
  endtask

  logic [2:0] fl;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(0, "123456789",   0, 32'h4B37, 0);
    vecs[1] = mk(0, "1234567897K", 0, 32'h0000, 1);   // appended 37 4B
    vecs[2] = mk(0, "",            0, 32'hFFFF, 0);   // empty frame, keep=0
    vecs[3] = mk(1, "123456789",   0, 32'h29B1, 0);
    vecs[4] = mk(1, "123456789)",  0, 32'h0000, 1);   // appended 29 B1
    vecs[4].data[87:80] = 8'hB1;
    vecs[4].len         = 5'd11;
    vecs[5] = mk(1, "",            0, 32'hFFFF, 0);
    vecs[6] = mk(1, "123456789",   1, 32'h29B1, 0);   // closed by keep=0 beat
    vecs[7] = mk(2, "123456789",   0, 32'hCBF43926, 0);
    vecs[8] = mk(2, "",            0, 32'h00000000, 1);
    vecs[9] = mk(2, "12345678",    0, 32'h9AE0DAAF, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_crc_out", get_crc(0), 32'h0);
    fl = get_flags(0);
    check("rst_valid_ok", {30'h0, fl[2:1]}, 32'h0);
    check("rst_busy", {31'h0, d0_busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {29'h0, d0_ready, d1_ready, d2_ready}, 32'h7);

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      drive_frame(vecs[i]);
      fl = get_flags(int'(vecs[i].sel));
      check($sformatf("v%0d_crc_valid", i), {31'h0, fl[2]}, 32'h1);
      check($sformatf("v%0d_crc_out", i), get_crc(int'(vecs[i].sel)), vecs[i].crc);
      check($sformatf("v%0d_crc_ok", i), {31'h0, fl[1]}, {31'h0, vecs[i].ok});
      $display("vector %0d sel=%0d len=%0d crc=%08h", i, vecs[i].sel, vecs[i].len,
               get_crc(int'(vecs[i].sel)));
    end

    // Back-pressure on the result
    d0_crdy = 1'b0;
    drive_frame(vecs[0]);
    for (int c = 0; c < 3; c++) begin
      fl = get_flags(0);
      check($sformatf("stall%0d_valid", c), {31'h0, fl[2]}, 32'h1);
      check($sformatf("stall%0d_crc", c), get_crc(0), 32'h4B37);
      check($sformatf("stall%0d_in_ready", c), {31'h0, fl[0]}, 32'h0);
      @(negedge clk);
    end
    d0_crdy = 1'b1;
    drive_frame(vecs[0]);
    check("after_stall_crc", get_crc(0), 32'h4B37);
    $display("stall sequence crc=%04h", d0_crc);

    // clr mid-frame, with a last beat offered in the clr cycle
    drive_beat(0, 32'h0000A55A, 4'h3, 1'b0);
    drive_beat(0, 32'h00001234, 4'h3, 1'b0);
    drive_beat(0, 32'h00005678, 4'h3, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    release_inputs();
    fl = get_flags(0);
    check("clr_valid", {31'h0, fl[2]}, 32'h0);
    check("clr_busy", {31'h0, d0_busy}, 32'h0);
    check("clr_in_ready", {31'h0, fl[0]}, 32'h1);
    drive_frame(vecs[0]);
    check("after_clr_crc", get_crc(0), 32'h4B37);
    $display("clr sequence crc=%04h", d0_crc);

    // Asynchronous reset mid-frame
    drive_beat(0, 32'h0000BEEF, 4'h3, 1'b0);
    drive_beat(0, 32'h0000CAFE, 4'h3, 1'b0);
    @(negedge clk);
    release_inputs();
    check("pre_rst_busy", {31'h0, d0_busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_crc_out", get_crc(0), 32'h0);
    fl = get_flags(0);
    check("mid_rst_valid_ok", {30'h0, fl[2:1]}, 32'h0);
    check("mid_rst_busy", {31'h0, d0_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_frame(vecs[0]);
    check("after_rst_crc", get_crc(0), 32'h4B37);
    $display("rst sequence crc=%04h", d0_crc);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
